led_display_arbiter: RTL and testbench
======================================

# led_display_arbiter

Round-robin arbiter and sequencer that shares the board's 8 LEDs between up to `NUM_REQ` display requesters, such as counter, status and debug pattern sources. It generates a slow display tick from the system clock and grants the LEDs to one requester at a time. A requester is preempted after `SLOT_TICKS` ticks only when another requester is waiting. The block sits between the pattern sources and the top-level LED pins.

## Interface
Parameters:
- `CLK_DIV`, default 1200000: clock cycles per display tick (12 MHz clock gives 10 Hz). Minimum 2.
- `NUM_REQ`, default 4: number of requesters. Range 2..8.
- `SLOT_TICKS`, default 8: ticks an owner keeps the LEDs before preemption is possible. Minimum 1.

Ports:
- `clk` input 1: system clock. This is the only clock.
- `rst` input 1: reset. Synchronous and active-high.
- `req` input `NUM_REQ`: per-requester request level. Held high while the requester wants the LEDs.
- `pattern` input `8*NUM_REQ`: requester i's pattern is on bits `[8*i+7:8*i]`.
- `grant` output `NUM_REQ`: one-hot grant, registered. All zero when no requester owns the LEDs.
- `owner` output `$clog2(NUM_REQ)`: index of the current or last owner.
- `busy` output 1: high in GRANT.
- `tick` output 1: one-cycle pulse every `CLK_DIV` cycles.
- `leds` output 8: LED drive, registered.

## Operation
- Divider: `div_cnt` counts 0..`CLK_DIV-1` and wraps to 0. `tick` is asserted in the cycle `div_cnt == CLK_DIV-1`. The divider free-runs in every state.
- FSM states are IDLE, GRANT and SWITCH.
- IDLE:
  - `grant` = 0 and `busy` = 0.
  - If any `req` bit is set, select the first set bit searching from `owner+1` upward, with wrap.
  - Load `grant` and `owner`, clear `slot_cnt`, and go to GRANT.
- GRANT:
  - `leds` <= `pattern[owner]` every cycle.
  - `slot_cnt` increments on `tick` and saturates at `SLOT_TICKS-1`.
  - Leave GRANT for SWITCH in either of these cases:
    - `req[owner]` = 0 (release).
    - `tick` is asserted while `slot_cnt == SLOT_TICKS-1` and any other `req` bit is set (preemption).
  - If no other requester is waiting at expiry, the owner keeps the LEDs indefinitely.
  - Release has priority over preemption when both occur in the same cycle; the result is identical.
- SWITCH:
  - Lasts exactly one cycle, with `grant` = 0, `busy` = 0 and `leds` = 0x00 (blank gap).
  - Arbitrates the same way as IDLE, searching from `owner+1` with wrap.
  - The former owner can be selected again only if no other bit is set.
  - If no requests are present, go to IDLE.
- Requests arriving during GRANT are not latched. The arbiter samples them only in IDLE or SWITCH, or when checking for preemption.
- Reset values:
  - state IDLE, `div_cnt` 0, `slot_cnt` 0.
  - `owner` = `NUM_REQ-1`, so requester 0 has first priority.
  - `grant` 0, `busy` 0, `tick` 0, `leds` 0x00.

## Timing
- Request to grant: `req` sampled high in IDLE at edge N gives `grant` and `busy` valid after edge N. `leds` shows the pattern after edge N+1.
- Pattern follow latency in GRANT: 1 cycle.
- Release: `req[owner]` sampled low at edge N gives `grant` = 0 and `leds` = 0 after edge N. The new grant is valid after edge N+1.
- Preemption takes effect on the cycle after the qualifying tick, followed by the one-cycle SWITCH gap.
- Reset mid-operation: all registers return to their reset values on the next edge. There is no partial grant.

## Configuration
- Macro `LED_ARB_IDLE_COUNT_EN`.
- Defined:
  - An 8-bit `idle_cnt` increments on each `tick` while in IDLE and wraps 0xFF to 0x00.
  - `leds` = `idle_cnt` in IDLE.
  - `idle_cnt` holds its value outside IDLE and is cleared only by `rst`.
- Undefined: `leds` = 0x00 in IDLE, and no `idle_cnt` register is built.
- SWITCH blanks the LEDs (0x00) in both builds.

## Test plan
Unless stated, parameters are `CLK_DIV`=4, `SLOT_TICKS`=2 and `NUM_REQ`=4.
- Reset: `rst` high for 2 cycles, then low. Check `grant`=0, `leds`=0x00, `busy`=0. `tick` first pulses in the 4th cycle after release, then every 4 cycles.
- Single request: `req`=4'b0100 with pattern2=0xA5. Check `grant`=4'b0100 one cycle later and `leds`=0xA5 two cycles later. The grant holds for more than 20 ticks with no preemption.
- Round-robin preemption: from IDLE, `req`=4'b0011. Check:
  - requester 0 is granted first;
  - after the 2nd tick it is preempted, with one SWITCH cycle (`grant`=0, `leds`=0x00);
  - `grant`=4'b0010, then after 2 more ticks back to 4'b0001.
- Release: the owner drops `req` with no others pending. Check `grant`=0 on the next cycle, SWITCH lasts 1 cycle, then IDLE; the next request goes to the index after the former owner.
- Reset mid-GRANT: assert `rst` while `leds`=0xA5. Check that all outputs are at reset values on the next edge and that requester 0 wins the first arbitration after reset.
- `LED_ARB_IDLE_COUNT_EN` defined, no requests: check `leds` steps 0x00, 0x01, 0x02, … once per tick and wraps 0xFF to 0x00. The value freezes during a grant and resumes counting afterwards.

Source files
------------

// File: rtl/led_display_arbiter.sv
// ============================================================================
// led_display_arbiter
// Round-robin owner of the 8 board LEDs with a slow display tick and slot
// preemption. Optional macro LED_ARB_IDLE_COUNT_EN shows an idle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_display_arbiter #(
  parameter int CLK_DIV    = 1200000,
  parameter int NUM_REQ    = 4,
  parameter int SLOT_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       pattern,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       tick,
  output logic [7:0]                 leds
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int OW = $clog2(NUM_REQ);
  localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [DW-1:0] c_div_last  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] c_slot_last = SW'(SLOT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SWITCH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           leds_q, leds_d;

  logic                 arb_found;
  logic [OW-1:0]        arb_sel;
  logic [OW-1:0]        cand;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [NUM_REQ-1:0]   owner_mask;
  logic                 others_req;
  logic                 preempt;
  logic [7:0]           idle_leds;

  assign tick      = (div_cnt_q == c_div_last);
  assign div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);

  // Search starts just past the current owner, so the owner itself is the last candidate.
  always_comb begin
    arb_found  = 1'b0;
    arb_sel    = owner_q;
    cand       = owner_q;
    sel_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(owner_q) + k) % NUM_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
    sel_onehot[arb_sel] = 1'b1;
  end

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
  end

  assign others_req = |(req & ~owner_mask);
  assign preempt    = tick && (slot_cnt_q == c_slot_last) && others_req;

`ifdef LED_ARB_IDLE_COUNT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  assign idle_cnt_d = (state_q == S_IDLE && tick) ? idle_cnt_q + 8'd1 : idle_cnt_q;
  assign idle_leds  = idle_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= 8'h00;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign idle_leds = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    leds_d     = leds_q;
    case (state_q)
      S_IDLE, S_SWITCH: begin
        grant_d = '0;
        leds_d  = 8'h00;
        if (arb_found) begin
          state_d    = S_GRANT;
          owner_d    = arb_sel;
          grant_d    = sel_onehot;
          slot_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
          leds_d  = idle_leds;
        end
      end
      S_GRANT: begin
        if (tick && slot_cnt_q != c_slot_last) begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
        if (!req[owner_q] || preempt) begin
          state_d = S_SWITCH;
          grant_d = '0;
          leds_d  = 8'h00;
        end else begin
          leds_d = pattern[{owner_q, 3'b000} +: 8];
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        leds_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      slot_cnt_q <= '0;
      owner_q    <= OW'(NUM_REQ - 1);
      grant_q    <= '0;
      leds_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      leds_q     <= leds_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = (state_q == S_GRANT);
  assign leds  = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_led_display_arbiter.sv
// ============================================================================
// tb_led_display_arbiter
// Vector table driven at negedge, expectations queued and checked after posedge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_display_arbiter;

  localparam int CLK_DIV    = 4;
  localparam int NUM_REQ    = 4;
  localparam int SLOT_TICKS = 2;
  localparam logic [31:0] c_pat  = 32'h3CA50F81;
  localparam logic [31:0] c_pat2 = 32'h3C5A0F81;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = c_pat;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        tick;
  logic [7:0]  leds;

  led_display_arbiter #(
    .CLK_DIV    (CLK_DIV),
    .NUM_REQ    (NUM_REQ),
    .SLOT_TICKS (SLOT_TICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .tick    (tick),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  leds;
    logic        in_idle;
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       tick;
    logic [7:0] leds;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] p,
                     input logic [3:0] g, input logic b, input logic [7:0] l,
                     input logic idl, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.pat = p; v.grant = g; v.busy = b;
    v.leds = l; v.in_idle = idl; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input string field,
                     input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h at %0t", nm, field, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "grant", 32'(grant), 32'(e.grant));
      chk(e.name, "owner", 32'(owner), 32'(e.owner));
      chk(e.name, "busy",  32'(busy),  32'(e.busy));
      chk(e.name, "tick",  32'(tick),  32'(e.tick));
      chk(e.name, "leds",  32'(leds),  32'(e.leds));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    logic [7:0] m_idle;
    logic [1:0] m_owner;
    logic       prev_idle;
    logic       prev_tick;
    exp_t       e;

    // Reset and idle: tick first shows in the 4th cycle after release
    add(1, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "reset0");
    add(1, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "reset1");
    for (int i = 0; i < 3; i++) add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "idle");
    // Single request, long hold with no preemption
    add(0, 4'b0100, c_pat, 4'b0100, 1, 8'h00, 0, "req2_grant");
    add(0, 4'b0100, c_pat, 4'b0100, 1, 8'hA5, 0, "req2_leds");
    for (int i = 0; i < 90; i++) add(0, 4'b0100, c_pat, 4'b0100, 1, 8'hA5, 0, "hold2");
    add(0, 4'b0100, c_pat2, 4'b0100, 1, 8'h5A, 0, "pattern_follow");
    add(0, 4'b0100, c_pat,  4'b0100, 1, 8'hA5, 0, "pattern_back");
    // Release with nothing pending, then the next grant goes past the old owner
    add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 0, "release_switch");
    add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "release_idle");
    add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "idle_after");
    add(0, 4'b1111, c_pat, 4'b1000, 1, 8'h00, 0, "next_after_owner");
    add(0, 4'b1111, c_pat, 4'b1000, 1, 8'h3C, 0, "owner3_leds");
    add(0, 4'b0100, c_pat, 4'b0000, 0, 8'h00, 0, "rel3_switch");
    add(0, 4'b0100, c_pat, 4'b0100, 1, 8'h00, 0, "switch_to2");
    add(0, 4'b0100, c_pat, 4'b0100, 1, 8'hA5, 0, "leds_a5");
    // Reset in the middle of a grant
    add(1, 4'b1111, c_pat, 4'b0000, 0, 8'h00, 1, "rst_mid");
    add(0, 4'b1111, c_pat, 4'b0001, 1, 8'h00, 0, "post_rst_req0");
    // Round-robin preemption between requesters 0 and 1
    add(1, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "rst_rr");
    add(0, 4'b0011, c_pat, 4'b0001, 1, 8'h00, 0, "rr_grant0");
    for (int i = 0; i < 6; i++) add(0, 4'b0011, c_pat, 4'b0001, 1, 8'h81, 0, "rr_own0");
    add(0, 4'b0011, c_pat, 4'b0000, 0, 8'h00, 0, "rr_gap0");
    add(0, 4'b0011, c_pat, 4'b0010, 1, 8'h00, 0, "rr_grant1");
    for (int i = 0; i < 6; i++) add(0, 4'b0011, c_pat, 4'b0010, 1, 8'h0F, 0, "rr_own1");
    add(0, 4'b0011, c_pat, 4'b0000, 0, 8'h00, 0, "rr_gap1");
    add(0, 4'b0011, c_pat, 4'b0001, 1, 8'h00, 0, "rr_back0");
    add(0, 4'b0011, c_pat, 4'b0001, 1, 8'h81, 0, "rr_back0_leds");
`ifdef LED_ARB_IDLE_COUNT_EN
    // Idle counter: long idle run wraps, freezes through a grant, then resumes
    add(1, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "rst_idlecnt");
    for (int i = 0; i < 1030; i++) add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "idlecnt");
    add(0, 4'b0001, c_pat, 4'b0001, 1, 8'h00, 0, "idlecnt_grant");
    for (int i = 0; i < 6; i++) add(0, 4'b0001, c_pat, 4'b0001, 1, 8'h81, 0, "idlecnt_hold");
    add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 0, "idlecnt_switch");
    for (int i = 0; i < 10; i++) add(0, 4'b0000, c_pat, 4'b0000, 0, 8'h00, 1, "idlecnt_resume");
`endif

    k         = 0;
    m_idle    = 8'h00;
    m_owner   = 2'd3;
    prev_idle = 1'b1;
    prev_tick = 1'b0;
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      rst     = vecs[n].rst;
      req     = vecs[n].req;
      pattern = vecs[n].pat;
      if (vecs[n].rst) begin
        k       = 0;
        m_idle  = 8'h00;
        m_owner = 2'd3;
      end else begin
        if (prev_idle && prev_tick) m_idle = m_idle + 8'd1;
        k++;
      end
      for (int i = 0; i < 4; i++) if (vecs[n].grant[i]) m_owner = 2'(i);
      e.grant = vecs[n].grant;
      e.owner = m_owner;
      e.busy  = vecs[n].busy;
      e.tick  = ((k % CLK_DIV) == CLK_DIV - 1);
`ifdef LED_ARB_IDLE_COUNT_EN
      e.leds  = vecs[n].in_idle ? m_idle : vecs[n].leds;
`else
      e.leds  = vecs[n].leds;
`endif
      e.name  = vecs[n].name;
      exp_q.push_back(e);
      prev_idle = vecs[n].in_idle;
      prev_tick = e.tick;
    end
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
